// File: rtl/mc_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | mc_ctrl_pkg                                                          |
// | State, opcode and datapath-select encodings for the RV32I sequencer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CL_LOAD   = 3'd0,
    CL_STORE  = 3'd1,
    CL_ALUR   = 3'd2,
    CL_ALUI   = 3'd3,
    CL_LUI    = 3'd4,
    CL_BRANCH = 3'd5,
    CL_JAL    = 3'd6,
    CL_JALR   = 3'd7
  } op_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] MEMOP_NONE  = 2'b00;
  localparam logic [1:0] MEMOP_READ  = 2'b01;
  localparam logic [1:0] MEMOP_WRITE = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_LUI    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

`default_nettype wire

// File: rtl/op_class_decode.sv
// +----------------------------------------------------------------------+
// | op_class_decode                                                      |
// | Maps the 7-bit opcode to an instruction class plus a legal flag.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module op_class_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output op_class_t  o_class,
  output logic       o_legal
);

  always_comb begin
    o_class = CL_ALUR;
    o_legal = 1'b1;
    case (i_op)
      OP_LOAD:   o_class = CL_LOAD;
      OP_STORE:  o_class = CL_STORE;
      OP_ALUR:   o_class = CL_ALUR;
      OP_ALUI:   o_class = CL_ALUI;
      OP_LUI:    o_class = CL_LUI;
      OP_BRANCH: o_class = CL_BRANCH;
      OP_JAL:    o_class = CL_JAL;
      OP_JALR:   o_class = CL_JALR;
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// +----------------------------------------------------------------------+
// | mc_control_fsm                                                       |
// | Multicycle RV32I control sequencer: state register + output decode. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic [1:0] MemOp,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       IllegalOp
);

  state_t    r_state;
  state_t    w_next;
  op_class_t w_class;
  logic      w_legal;

  op_class_decode u_op_class_decode (
    .i_op    (op),
    .o_class (w_class),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemOp     = MEMOP_NONE;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    ImmSrc    = IMM_I;
    IllegalOp = 1'b0;
    // Reset masks every output, including an in-flight memory request.
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          MemOp     = MEMOP_READ;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
          if (MemReady) w_next = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          if (w_legal && w_class == CL_BRANCH) ImmSrc = IMM_B;
          else if (w_legal && w_class == CL_JAL) ImmSrc = IMM_J;
          if (!w_legal) begin
            IllegalOp = 1'b1;
            w_next    = S_FETCH;
          end else begin
            case (w_class)
              CL_LOAD, CL_STORE: w_next = S_MEMADR;
              CL_ALUR:           w_next = S_EXECR;
              CL_ALUI:           w_next = S_EXECI;
              CL_LUI:            w_next = S_LUI;
              CL_BRANCH:         w_next = S_BRANCH;
              CL_JAL:            w_next = S_JAL;
              default:           w_next = S_JALR;
            endcase
          end
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = (w_class == CL_STORE) ? IMM_S : IMM_I;
          w_next  = (w_class == CL_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          AdrSrc = 1'b1;
          MemOp  = MEMOP_READ;
          if (MemReady) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = RES_RDATA;
          RegWrite  = 1'b1;
          w_next    = S_FETCH;
        end
        S_MEMWRITE: begin
          AdrSrc = 1'b1;
          MemOp  = MEMOP_WRITE;
          if (MemReady) w_next = S_FETCH;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_FUNCT;
          w_next  = S_ALUWB;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
          w_next  = S_ALUWB;
        end
        S_LUI: begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_LUI;
          ImmSrc  = IMM_U;
          w_next  = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALUOP_BRANCH;
          PCWrite = Zero;
          w_next  = S_FETCH;
        end
        S_JALR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          w_next  = S_JAL;
        end
        S_JAL: begin
          // PC takes the target held in ALUOut while the ALU forms OldPC+4.
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
          w_next  = S_ALUWB;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire
